// File: rtl/strt_qualifier_if.sv
// Handshake bundle between the UART start-bit qualifier and its receive FSM.
// The master drives line and control; the slave (the qualifier) returns pulses and status.
interface strt_qualifier_if #(
  parameter int PRESC_W = 6,
  parameter int GCNT_W  = 8
);
  logic               enable;
  logic [PRESC_W-1:0] prescale;
  logic               rx_in;
  logic               clr_cnt;
  logic               strt_valid;
  logic               strt_glitch;
  logic               busy;
  logic [GCNT_W-1:0]  glitch_cnt;

  modport master (
    output enable, prescale, rx_in, clr_cnt,
    input  strt_valid, strt_glitch, busy, glitch_cnt
  );

  modport slave (
    input  enable, prescale, rx_in, clr_cnt,
    output strt_valid, strt_glitch, busy, glitch_cnt
  );
endinterface

// File: rtl/strt_qualifier.sv
// UART start-bit qualifier: synchronises rx, detects the falling edge and
// majority-votes NSAMP samples around mid-bit, emitting valid/glitch pulses.
module strt_qualifier #(
  parameter int PRESC_W = 6,
  parameter int NSAMP   = 3,
  parameter int GCNT_W  = 8
) (
  input  logic             CLK,
  input  logic             RST,
  strt_qualifier_if.slave  bus
);

  localparam int                 VW        = (NSAMP > 1) ? NSAMP - 1 : 1;
  localparam logic [PRESC_W-1:0] HALF_W    = PRESC_W'((NSAMP - 1) / 2);
  localparam logic [PRESC_W-1:0] PRESC_MIN = PRESC_W'(NSAMP + 2);
  localparam logic [3:0]         VOTE_THR  = 4'(NSAMP / 2);
  localparam logic [GCNT_W-1:0]  GCNT_MAX  = {GCNT_W{1'b1}};

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SAMPLE = 1'b1} state_t;

  state_t             state_r, state_nxt_s;
  logic               sync_meta_r, rx_sync_r, rx_prev_r;
  logic [PRESC_W-1:0] cnt_r, presc_q_r;
  logic [VW-1:0]      vote_r;
  logic               valid_r, glitch_r, busy_r;
  logic [GCNT_W-1:0]  gcnt_r;

  logic               fall_s, last_tick_s, store_s, pass_s;
  logic               valid_nxt_s, glitch_nxt_s, busy_nxt_s;
  logic [PRESC_W-1:0] mid_s, first_s, last_s, idx_s, presc_clamp_s;
  logic [3:0]         zeros_s;

  // Two-flop synchroniser followed by the edge-history flop; idle line is high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_meta_r <= 1'b1;
      rx_sync_r   <= 1'b1;
      rx_prev_r   <= 1'b1;
    end else begin
      sync_meta_r <= bus.rx_in;
      rx_sync_r   <= sync_meta_r;
      rx_prev_r   <= rx_sync_r;
    end
  end

  // Sample window derived from the latched prescale, plus edge detect and clamp.
  always_comb begin
    mid_s         = presc_q_r >> 1;
    first_s       = mid_s - HALF_W;
    last_s        = mid_s + HALF_W;
    idx_s         = cnt_r - first_s;
    fall_s        = bus.enable & ~rx_sync_r & rx_prev_r;
    last_tick_s   = (cnt_r == last_s);
    store_s       = (cnt_r >= first_s) && (cnt_r < last_s);
    presc_clamp_s = (bus.prescale < PRESC_MIN) ? PRESC_MIN : bus.prescale;
  end

  // Majority vote over the stored samples and the live sample on the last tick.
  always_comb begin
    zeros_s = {3'b000, ~rx_sync_r};
    for (int i = 0; i < NSAMP - 1; i++) begin
      zeros_s = zeros_s + {3'b000, ~vote_r[i]};
    end
    pass_s = (zeros_s > VOTE_THR);
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; dropping enable aborts a qualification silently.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fall_s) begin
          state_nxt_s = ST_SAMPLE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SAMPLE: begin
        if (!bus.enable || last_tick_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SAMPLE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode; values are registered below so pulses are glitch-free.
  always_comb begin
    valid_nxt_s  = 1'b0;
    glitch_nxt_s = 1'b0;
    busy_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_nxt_s = fall_s;
      end
      ST_SAMPLE: begin
        if (bus.enable && last_tick_s) begin
          valid_nxt_s  = pass_s;
          glitch_nxt_s = ~pass_s;
          busy_nxt_s   = 1'b0;
        end else begin
          busy_nxt_s   = bus.enable;
        end
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered pulse and status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_r  <= 1'b0;
      glitch_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      valid_r  <= valid_nxt_s;
      glitch_r <= glitch_nxt_s;
      busy_r   <= busy_nxt_s;
    end
  end

  // Tick counter and prescale latch; prescale is frozen for the whole window.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r     <= '0;
      presc_q_r <= '0;
    end else if (state_r == ST_IDLE) begin
      if (fall_s) begin
        cnt_r     <= PRESC_W'(1);
        presc_q_r <= presc_clamp_s;
      end
    end else begin
      cnt_r <= cnt_r + PRESC_W'(1);
    end
  end

  // Vote register: one slot per sample tick before the last one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vote_r <= '0;
    end else if ((state_r == ST_SAMPLE) && store_s) begin
      for (int i = 0; i < VW; i++) begin
        if (idx_s == PRESC_W'(i)) begin
          vote_r[i] <= rx_sync_r;
        end
      end
    end
  end

  // Saturating glitch counter; clear wins over a simultaneous glitch pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      gcnt_r <= '0;
    end else if (bus.clr_cnt) begin
      gcnt_r <= '0;
    end else if (glitch_r && (gcnt_r != GCNT_MAX)) begin
      gcnt_r <= gcnt_r + GCNT_W'(1);
    end
  end

  assign bus.strt_valid  = valid_r;
  assign bus.strt_glitch = glitch_r;
  assign bus.busy        = busy_r;
  assign bus.glitch_cnt  = gcnt_r;

endmodule

// File: tb/tb_strt_qualifier.sv
// Directed bench for strt_qualifier: dut_a uses NSAMP=3/GCNT_W=8, dut_b uses
// NSAMP=5/GCNT_W=2; both see the same line and control stimulus.
module tb_strt_qualifier;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       rx  = 1'b1;
  logic       en  = 1'b1;
  logic       clr = 1'b0;
  logic [5:0] presc = 6'd16;

  int errs = 0, checks = 0;
  int edge_n = 0, t0 = 0;
  int va = 0, ga = 0, ba = 0, vb = 0, gb = 0, excl = 0;
  int va_edge = 0, ga_edge = 0, vb_edge = 0;
  int s_va, s_ga, s_ba, s_vb, s_gb;
  logic pa = 1'b0, pb = 1'b0;

  strt_qualifier_if #(.PRESC_W(6), .GCNT_W(8)) ia ();
  strt_qualifier_if #(.PRESC_W(6), .GCNT_W(2)) ib ();

  assign ia.rx_in = rx;  assign ia.enable = en;  assign ia.clr_cnt = clr;  assign ia.prescale = presc;
  assign ib.rx_in = rx;  assign ib.enable = en;  assign ib.clr_cnt = clr;  assign ib.prescale = presc;

  strt_qualifier #(.PRESC_W(6), .NSAMP(3), .GCNT_W(8)) dut_a (.CLK(CLK), .RST(RST), .bus(ia.slave));
  strt_qualifier #(.PRESC_W(6), .NSAMP(5), .GCNT_W(2)) dut_b (.CLK(CLK), .RST(RST), .bus(ib.slave));

  always #5 CLK = ~CLK;

  always @(posedge CLK) edge_n <= edge_n + 1;

  // Pulse/busy monitor sampled on the falling edge, plus exclusivity tracking.
  always @(negedge CLK) begin
    if (ia.strt_valid === 1'b1) begin va <= va + 1; va_edge <= edge_n; end
    if (ia.strt_glitch === 1'b1) begin ga <= ga + 1; ga_edge <= edge_n; end
    if (ia.busy === 1'b1) ba <= ba + 1;
    if (ib.strt_valid === 1'b1) begin vb <= vb + 1; vb_edge <= edge_n; end
    if (ib.strt_glitch === 1'b1) gb <= gb + 1;
    if ((ia.strt_valid && ia.strt_glitch) || ((ia.strt_valid || ia.strt_glitch) && pa)) excl <= excl + 1;
    if ((ib.strt_valid && ib.strt_glitch) || ((ib.strt_valid || ib.strt_glitch) && pb)) excl <= excl + 1;
    pa <= ia.strt_valid | ia.strt_glitch;
    pb <= ib.strt_valid | ib.strt_glitch;
  end

  task automatic check_val(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic snap();
    s_va = va; s_ga = ga; s_ba = ba; s_vb = vb; s_gb = gb;
  endtask

  // pat[i] is the rx_in value sampled at edge t0+i.
  task automatic send(input logic [31:0] pat, input int len);
    snap();
    t0 = edge_n + 1;
    for (int i = 0; i < len; i++) begin
      rx = pat[i];
      tick();
    end
    rx = 1'b1;
    repeat (6) tick();
  endtask

  initial begin
    repeat (3) tick();
    check_val("rst_valid", int'(ia.strt_valid), 0);
    check_val("rst_glitch", int'(ia.strt_glitch), 0);
    check_val("rst_busy", int'(ia.busy), 0);
    check_val("rst_gcnt_a", int'(ia.glitch_cnt), 0);
    check_val("rst_gcnt_b", int'(ib.glitch_cnt), 0);
    RST = 1'b0;
    repeat (3) tick();

    // Clean start, prescale 16
    send(32'h0000_0000, 16);
    check_val("clean_valid_a", va - s_va, 1);
    check_val("clean_edge_a", va_edge, t0 + 11);
    check_val("clean_glitch_a", ga - s_ga, 0);
    check_val("clean_busy_a", ba - s_ba, 9);
    check_val("clean_gcnt_a", int'(ia.glitch_cnt), 0);
    check_val("clean_edge_b", vb_edge, t0 + 12);

    // Short glitch: four low ticks
    send(32'hFFFF_FFF0, 16);
    check_val("short_glitch_a", ga - s_ga, 1);
    check_val("short_edge_a", ga_edge, t0 + 11);
    check_val("short_valid_a", va - s_va, 0);
    check_val("short_gcnt_a", int'(ia.glitch_cnt), 1);
    check_val("short_glitch_b", gb - s_gb, 1);

    // Majority vote on the five-sample instance
    send(32'h0000_0080, 16);
    check_val("maj7_valid_b", vb - s_vb, 1);
    check_val("maj7_glitch_b", gb - s_gb, 0);
    send(32'h0000_00C0, 16);
    check_val("maj67_valid_b", vb - s_vb, 1);
    check_val("maj67_valid_a", va - s_va, 1);
    send(32'h0000_01C0, 16);
    check_val("maj678_glitch_b", gb - s_gb, 1);
    check_val("maj678_glitch_a", ga - s_ga, 1);
    check_val("maj678_gcnt_b", int'(ib.glitch_cnt), 2);

    // Abort: enable drops while cnt==5
    snap();
    t0 = edge_n + 1;
    for (int i = 0; i < 16; i++) begin
      if (i == 7) en = 1'b0;
      if (i == 8) check_val("abort_busy_a", int'(ia.busy), 0);
      rx = 1'b0;
      tick();
    end
    rx = 1'b1;
    repeat (4) tick();
    en = 1'b1;
    repeat (4) tick();
    check_val("abort_pulses_a", (va - s_va) + (ga - s_ga), 0);
    check_val("abort_pulses_b", (vb - s_vb) + (gb - s_gb), 0);
    check_val("abort_gcnt_a", int'(ia.glitch_cnt), 2);

    // Line held low: exactly one detection
    send(32'h0000_0000, 32);
    check_val("held_valid_a", va - s_va, 1);
    check_val("held_glitch_a", ga - s_ga, 0);

    // Three more glitches: dut_b saturates at 3
    for (int k = 0; k < 3; k++) send(32'hFFFF_FFF0, 16);
    check_val("sat_gcnt_b", int'(ib.glitch_cnt), 3);
    check_val("sat_gcnt_a", int'(ia.glitch_cnt), 5);

    // Clear coinciding with glitch pulses
    snap();
    t0 = edge_n + 1;
    for (int i = 0; i < 16; i++) begin
      if (i == 12) clr = 1'b1;
      if (i == 14) clr = 1'b0;
      rx = (i < 4) ? 1'b0 : 1'b1;
      tick();
    end
    repeat (4) tick();
    check_val("clr_edge_a", ga_edge, t0 + 11);
    check_val("clr_glitch_b", gb - s_gb, 1);
    check_val("clr_gcnt_a", int'(ia.glitch_cnt), 0);
    check_val("clr_gcnt_b", int'(ib.glitch_cnt), 0);

    // Prescale clamp: 2 behaves as NSAMP+2
    presc = 6'd2;
    send(32'h0000_0000, 16);
    check_val("clamp_edge_a", va_edge, t0 + 5);
    check_val("clamp_busy_a", ba - s_ba, 3);
    check_val("clamp_edge_b", vb_edge, t0 + 7);
    presc = 6'd16;

    // Reset in the middle of a qualification (cnt==6)
    snap();
    t0 = edge_n + 1;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin RST = 1'b1; rx = 1'b1; end
      else if (i < 8) rx = 1'b0;
      if (i == 9) begin
        check_val("rstmid_busy_a", int'(ia.busy), 0);
        check_val("rstmid_valid_a", int'(ia.strt_valid), 0);
      end
      if (i == 10) RST = 1'b0;
      tick();
    end
    repeat (4) tick();
    check_val("rstmid_pulses_a", (va - s_va) + (ga - s_ga), 0);
    check_val("rstmid_pulses_b", (vb - s_vb) + (gb - s_gb), 0);

    check_val("exclusive", excl, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
